down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer_pkg.sv | 12 +
 rtl/down_timer_word_dec.sv | 13 +
 rtl/down_timer.sv | 105 ++++++++++
 tb/tb_down_timer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer block: state encoding and default word width.
package down_timer_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/down_timer_word_dec.sv
// Combinational WIDTH-bit decrement-by-one; wraps modulo 2^WIDTH.
module word_dec
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = a - {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter with start/stop control and a one-cycle expire pulse.
// Define DOWN_TIMER_AUTORELOAD_EN to reload the count on expiry and keep running.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expire_q, expire_d;
  logic [WIDTH-1:0] count_dec;
`ifdef DOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  logic count_zero;
  logic count_one;

  assign count_zero = (count_q == '0);
  assign count_one  = (count_q == {{(WIDTH-1){1'b0}}, 1'b1});

  word_dec #(
    .WIDTH (WIDTH)
  ) u_word_dec (
    .a (count_q),
    .y (count_dec)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    expire_d = 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = load_val;
      state_d = StIdle;
`ifdef DOWN_TIMER_AUTORELOAD_EN
      reload_d = load_val;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // A zero count has nothing to count down, so start is ignored.
          if (start && !stop && !count_zero) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StIdle;
          end else if (count_one) begin
            expire_d = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
            count_d  = reload_q;
`else
            count_d  = '0;
            state_d  = StDone;
`endif
          end else begin
            count_d = count_dec;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      expire_q <= 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      expire_q <= expire_d;
`ifdef DOWN_TIMER_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count  = count_q;
  assign busy   = (state_q == StRun);
  assign expire = expire_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized control
// traffic compared against a behavioural model.
module tb_down_timer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         expire;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: "running" flag, "finished" flag, counter value.
  bit           m_run;
  bit           m_fin;
  bit           m_exp;
  logic [W-1:0] m_count;
  logic [W-1:0] m_reload;

  down_timer #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .expire   (expire)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit ld, input logic [W-1:0] lv,
                            input bit st, input bit sp);
    m_exp = 1'b0;
    if (r) begin
      m_run = 0; m_fin = 0; m_count = 0; m_reload = 0;
    end else if (ld) begin
      m_run = 0; m_fin = 0; m_count = lv; m_reload = lv;
    end else if (m_run) begin
      if (sp) begin
        m_run = 0;
      end else if (m_count == 1) begin
        m_exp = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        m_count = m_reload;
`else
        m_count = 0; m_run = 0; m_fin = 1;
`endif
      end else begin
        m_count = m_count - 1;
      end
    end else if (st && !sp && m_count != 0) begin
      m_run = 1; m_fin = 0;
    end
  endtask

  // Drive one cycle of inputs, advance one clock edge, keep the model in step.
  task automatic tick(input bit r, input bit ld, input logic [W-1:0] lv,
                      input bit st, input bit sp);
    reset = r; load = ld; load_val = lv; start = st; stop = sp;
    @(posedge clk);
    model_step(r, ld, lv, st, sp);
    #1;
    reset = 0; load = 0; start = 0; stop = 0;
  endtask

  task automatic test_reset();
    tick(1, 1, 8'd7, 1, 0);
    tick(1, 0, 8'd0, 0, 0);
    n_checks++;
    if (count !== 8'd0) begin
      n_errors++; $display("FAIL reset_count got %0d want 0", count);
    end
    n_checks++;
    if (busy !== 1'b0 || expire !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags got busy=%b expire=%b want 0 0", busy, expire);
    end
  endtask

`ifndef DOWN_TIMER_AUTORELOAD_EN
  task automatic test_basic();
    int exp_seq[5] = '{4, 3, 2, 1, 0};
    int pulses = 0;
    tick(0, 1, 8'd5, 0, 0);
    n_checks++;
    if (count !== 8'd5 || busy !== 1'b0) begin
      n_errors++; $display("FAIL basic_load got count=%0d busy=%b want 5 0", count, busy);
    end
    tick(0, 0, 8'd0, 1, 0);
    n_checks++;
    if (count !== 8'd5 || busy !== 1'b1 || expire !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_start got count=%0d busy=%b exp=%b want 5 1 0", count, busy, expire);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 8'd0, 0, 0);
      n_checks++;
      if (count !== W'(exp_seq[i]) || expire !== (exp_seq[i] == 0)) begin
        n_errors++;
        $display("FAIL basic_step%0d got count=%0d exp=%b want %0d %b", i, count, expire,
                 exp_seq[i], exp_seq[i] == 0);
      end
      if (expire === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++; $display("FAIL basic_pulses got %0d want 1", pulses);
    end
    tick(0, 0, 8'd0, 0, 0);
    n_checks++;
    if (busy !== 1'b0 || expire !== 1'b0 || count !== 8'd0 || dut.state_q !== 2'b10) begin
      n_errors++;
      $display("FAIL basic_done got busy=%b exp=%b count=%0d state=%b want 0 0 0 10", busy,
               expire, count, dut.state_q);
    end
  endtask

  task automatic test_pause();
    int pulses = 0;
    tick(0, 1, 8'd4, 0, 0);
    tick(0, 0, 8'd0, 1, 0);
    tick(0, 0, 8'd0, 0, 0);
    tick(0, 0, 8'd0, 0, 0);
    n_checks++;
    if (count !== 8'd2) begin
      n_errors++; $display("FAIL pause_reach got %0d want 2", count);
    end
    tick(0, 0, 8'd0, 1, 1); // start+stop together resolves as stop
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (count !== 8'd2 || busy !== 1'b0 || expire !== 1'b0) begin
        n_errors++;
        $display("FAIL pause_hold%0d got count=%0d busy=%b want 2 0", i, count, busy);
      end
      tick(0, 0, 8'd0, 0, 0);
    end
    tick(0, 0, 8'd0, 1, 0);
    n_checks++;
    if (count !== 8'd2 || busy !== 1'b1) begin
      n_errors++; $display("FAIL pause_resume got count=%0d busy=%b want 2 1", count, busy);
    end
    tick(0, 0, 8'd0, 0, 0);
    if (expire === 1'b1) pulses++;
    n_checks++;
    if (count !== 8'd1) begin
      n_errors++; $display("FAIL pause_one got %0d want 1", count);
    end
    tick(0, 0, 8'd0, 0, 0);
    if (expire === 1'b1) pulses++;
    n_checks++;
    if (count !== 8'd0 || expire !== 1'b1) begin
      n_errors++; $display("FAIL pause_zero got count=%0d exp=%b want 0 1", count, expire);
    end
    tick(0, 0, 8'd0, 0, 0);
    if (expire === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1) begin
      n_errors++; $display("FAIL pause_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_stop_at_one();
    tick(0, 1, 8'd2, 0, 0);
    tick(0, 0, 8'd0, 1, 0);
    tick(0, 0, 8'd0, 0, 0);
    tick(0, 0, 8'd0, 0, 1);
    n_checks++;
    if (count !== 8'd1 || expire !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stop_one got count=%0d exp=%b busy=%b want 1 0 0", count, expire, busy);
    end
  endtask
`else
  task automatic test_autoreload();
    int exp_seq[7] = '{3, 2, 1, 3, 2, 1, 3};
    tick(0, 1, 8'd3, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick(0, 0, 8'd0, (i == 0), 0);
      n_checks++;
      if (count !== W'(exp_seq[i]) || busy !== 1'b1 || expire !== (i == 3 || i == 6)) begin
        n_errors++;
        $display("FAIL reload_step%0d got count=%0d busy=%b exp=%b want %0d 1 %b", i, count,
                 busy, expire, exp_seq[i], (i == 3 || i == 6));
      end
    end
    tick(0, 1, 8'd1, 0, 0);
    tick(0, 0, 8'd0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 8'd0, 0, 0);
      n_checks++;
      if (count !== 8'd1 || expire !== 1'b1 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL reload_one%0d got count=%0d exp=%b busy=%b want 1 1 1", i, count,
                 expire, busy);
      end
    end
  endtask
`endif

  task automatic test_zero_load();
    tick(0, 1, 8'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 8'd0, 1, 0);
      n_checks++;
      if (count !== 8'd0 || busy !== 1'b0 || expire !== 1'b0) begin
        n_errors++;
        $display("FAIL zero_load%0d got count=%0d busy=%b exp=%b want 0 0 0", i, count, busy,
                 expire);
      end
    end
  endtask

  task automatic test_load_priority();
    tick(0, 1, 8'd3, 0, 0);
    tick(0, 0, 8'd0, 1, 0);
    tick(0, 0, 8'd0, 0, 0);
    tick(0, 1, 8'd9, 1, 0);
    n_checks++;
    if (count !== 8'd9 || busy !== 1'b0 || expire !== 1'b0 || dut.state_q !== 2'b00) begin
      n_errors++;
      $display("FAIL load_prio got count=%0d busy=%b exp=%b state=%b want 9 0 0 00", count, busy,
               expire, dut.state_q);
    end
    tick(0, 0, 8'd0, 0, 0);
    n_checks++;
    if (count !== 8'd9) begin
      n_errors++; $display("FAIL load_prio_hold got %0d want 9", count);
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 1, 8'd2, 0, 0);
    tick(0, 0, 8'd0, 1, 0);
    tick(0, 0, 8'd0, 0, 0);
    tick(1, 0, 8'd0, 0, 0);
    n_checks++;
    if (count !== 8'd0 || busy !== 1'b0 || expire !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid got count=%0d busy=%b exp=%b want 0 0 0", count, busy, expire);
    end
    tick(0, 0, 8'd0, 0, 0);
    n_checks++;
    if (expire !== 1'b0 || count !== 8'd0) begin
      n_errors++; $display("FAIL reset_mid_after got count=%0d exp=%b want 0 0", count, expire);
    end
  endtask

  task automatic test_random();
    bit r, ld, st, sp;
    logic [W-1:0] lv;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 15) == 0);
      lv = W'($urandom_range(0, 7));
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 9) == 0);
      tick(r, ld, lv, st, sp);
      n_checks++;
      if (count !== m_count || busy !== m_run || expire !== m_exp) begin
        n_errors++;
        $display("FAIL random%0d got count=%0d busy=%b exp=%b want %0d %b %b", i, count, busy,
                 expire, m_count, m_run, m_exp);
      end
    end
  endtask

  initial begin
    m_run = 0; m_fin = 0; m_exp = 0; m_count = 0; m_reload = 0;
    test_reset();
`ifndef DOWN_TIMER_AUTORELOAD_EN
    test_basic();
    test_pause();
    test_stop_at_one();
`else
    test_autoreload();
`endif
    test_zero_load();
    test_load_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
